// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory: store widths and clear/ready FSM states.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SEL_SW   = 2'd0,
        SEL_SH   = 2'd1,
        SEL_SB   = 2'd2,
        SEL_RSVD = 2'd3
    } store_sel_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/data_mem_store_align.sv
// Maps a store request onto byte-lane enables and lane-replicated write data.
module store_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_store_sel,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    output logic [3:0]  o_be,
    output logic [31:0] o_lane_data
);

    always_comb begin
        o_be        = '0;
        o_lane_data = i_wdata;
        case (store_sel_e'(i_store_sel))
            SEL_SW: o_be = 4'b1111;
            SEL_SH: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_lane_data = {2{i_wdata[15:0]}};
            end
            SEL_SB: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_lane_data = {4{i_wdata[7:0]}};
            end
            default: o_be = '0;
        endcase
        if (!i_we) begin
            o_be = '0;
        end
    end

endmodule

// File: rtl/data_mem.sv
// Word-addressed data memory with byte-lane stores and a self-clearing walk after reset.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [1:0]  store_sel,
    output logic [31:0] rdata,
    output logic [3:0]  be,
    output logic        busy
);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_clr_idx;
    logic [31:0]         r_mem [2**ADDR_W];

    logic [ADDR_W-1:0]   w_idx;
    logic                w_store_we;
    logic [3:0]          w_be;
    logic [31:0]         w_lane_data;
    logic                w_unused_addr;

    assign w_idx         = addr[ADDR_W+1:2];
    assign w_unused_addr = ^addr[31:ADDR_W+2];
    assign w_store_we    = we && (r_state == ST_READY);

    store_align u_store_align (
        .i_addr_lo   (addr[1:0]),
        .i_store_sel (store_sel),
        .i_wdata     (wdata),
        .i_we        (w_store_we),
        .o_be        (w_be),
        .o_lane_data (w_lane_data)
    );

    // Reset takes priority, so a store presented alongside reset never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_mem[r_clr_idx] <= '0;
                    r_clr_idx        <= r_clr_idx + 1'b1;
                    if (r_clr_idx == '1) begin
                        r_state <= ST_READY;
                    end
                end
                default: begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (w_be[b]) begin
                            r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
                        end
                    end
                end
            endcase
        end
    end

    assign rdata = (r_state == ST_READY) ? r_mem[w_idx] : '0;
    assign be    = w_be;
    assign busy  = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: clear walk timing, byte-lane stores, read-during-write.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [1:0]  store_sel = 2'd0;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        busy;

    int checks = 0;
    int errors = 0;

    data_mem #(.ADDR_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .store_sel (store_sel),
        .rdata     (rdata),
        .be        (be),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        logic [31:0] rd_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Leaves the bench at the negedge following the reset edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts sampled busy cycles while presenting a word store to address 0.
    task automatic count_busy(output int n, output int viol);
        n = 0;
        viol = 0;
        while (busy && n < 5000) begin
            n++;
            we = 1'b1; store_sel = 2'd0; addr = 32'h0; wdata = 32'hDEADBEEF;
            #1;
            if (be !== 4'b0000 || rdata !== 32'h0) viol++;
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    initial begin
        int n;
        int viol;

        vecs[0]  = '{1'b1, 2'd0, 32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h10, 32'h1234_5678};
        vecs[1]  = '{1'b1, 2'd2, 32'h0000_0011, 32'h0000_00AB, 4'b0010, 32'h10, 32'h1234_AB78};
        vecs[2]  = '{1'b1, 2'd0, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h20, 32'h1122_3344};
        vecs[3]  = '{1'b1, 2'd1, 32'h0000_0022, 32'hFFFF_BEEF, 4'b1100, 32'h20, 32'hBEEF_3344};
        vecs[4]  = '{1'b1, 2'd1, 32'h0000_0020, 32'h0000_CAFE, 4'b0011, 32'h20, 32'hBEEF_CAFE};
        vecs[5]  = '{1'b1, 2'd2, 32'h0000_0023, 32'h1234_5699, 4'b1000, 32'h20, 32'h99EF_CAFE};
        vecs[6]  = '{1'b1, 2'd2, 32'h0000_0020, 32'h0000_0055, 4'b0001, 32'h20, 32'h99EF_CA55};
        vecs[7]  = '{1'b1, 2'd3, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h20, 32'h99EF_CA55};
        vecs[8]  = '{1'b1, 2'd1, 32'h0000_0013, 32'h0000_A5A5, 4'b1100, 32'h10, 32'hA5A5_AB78};
        vecs[9]  = '{1'b1, 2'd2, 32'h0000_0012, 32'h0000_0077, 4'b0100, 32'h10, 32'hA577_AB78};
        vecs[10] = '{1'b0, 2'd0, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h10, 32'hA577_AB78};
        vecs[11] = '{1'b1, 2'd0, 32'h0000_4010, 32'h0BAD_F00D, 4'b1111, 32'h10, 32'h0BAD_F00D};
        vecs[12] = '{1'b1, 2'd0, 32'hFFFF_FFFC, 32'h1357_9BDF, 4'b1111, 32'h3FFC, 32'h1357_9BDF};
        vecs[13] = '{1'b1, 2'd0, 32'h0000_0042, 32'h0102_0304, 4'b1111, 32'h40, 32'h0102_0304};

        // Power-on clear
        do_reset();
        check("busy_after_reset", {31'b0, busy}, 32'h1);
        count_busy(n, viol);
        check("clear_cycles", n, 32'd4096);
        check("clear_outputs_idle", viol, 32'd0);
        #1;
        check("busy_done", {31'b0, busy}, 32'h0);
        addr = 32'h0000_3FFC;
        #1;
        check("rd_last_word_zero", rdata, 32'h0);
        addr = 32'h0;
        #1;
        check("rd_word0_no_busy_store", rdata, 32'h0);

        // Table-driven stores
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            we = vecs[i].we; store_sel = vecs[i].sel;
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            #1;
            check($sformatf("be_vec%0d", i), {28'b0, be}, {28'b0, vecs[i].exp_be});
            @(negedge clk);
            we = 1'b0; addr = vecs[i].rd_addr;
            #1;
            check($sformatf("rdata_vec%0d", i), rdata, vecs[i].exp_rdata);
        end

        // Misaligned word store with read-during-write
        @(negedge clk);
        we = 1'b1; store_sel = 2'd0; addr = 32'h0000_1003; wdata = 32'hCAFE_BABE;
        #1;
        check("rdw_old_value", rdata, 32'h0);
        check("rdw_be", {28'b0, be}, 32'hF);
        @(negedge clk);
        we = 1'b0; addr = 32'h0000_1000;
        #1;
        check("rdw_new_value", rdata, 32'hCAFE_BABE);

        // Reset from READY with a store present, then reset again mid-clear
        @(negedge clk);
        reset = 1'b1; we = 1'b1; store_sel = 2'd0; addr = 32'h10; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        reset = 1'b0; we = 1'b0;
        #1;
        check("busy_after_ready_reset", {31'b0, busy}, 32'h1);
        check("rdata_zero_in_clear", rdata, 32'h0);
        repeat (100) @(negedge clk);
        do_reset();
        count_busy(n, viol);
        check("restart_clear_cycles", n, 32'd4096);
        check("restart_outputs_idle", viol, 32'd0);
        addr = 32'h10;
        #1;
        check("rd_0x10_cleared", rdata, 32'h0);
        addr = 32'h1000;
        #1;
        check("rd_0x1000_cleared", rdata, 32'h0);
        addr = 32'h0;
        #1;
        check("rd_0x0_cleared", rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
